// File: rtl/rvga_hazard_ctrl_pkg.sv
// Shared types for the rvga hazard controller: memory-wait FSM states and
// the width helper for the wait counter.
package rvga_types;

   typedef enum logic {
      WAIT_IDLE,
      WAIT_BUSY
   } rvga_wait_state_e;

   localparam int RVGA_TIMEOUT_CYC = 256;
   localparam int RVGA_WCNT_W      = $clog2(RVGA_TIMEOUT_CYC) + 1;

   // Wait counter must be able to reach TIMEOUT_CYC-1 with headroom to saturate.
   function automatic int rvga_wcnt_width(input int timeout_cyc);
      return $clog2(timeout_cyc) + 1;
   endfunction

endpackage

// File: rtl/rvga_hazard_ctrl_mem_wait_fsm.sv
// Per-port memory wait tracker: reports the stall condition and pulses
// timeout_o on the cycle the wait reaches TIMEOUT_CYC consecutive cycles.
module rvga_mem_wait_fsm
   import rvga_types::*;
#(
   parameter int TIMEOUT_CYC = RVGA_TIMEOUT_CYC
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_i,
   input  logic resp_i,
   output logic stall_o,
   output logic timeout_o
);

   localparam int                WCNT_W    = rvga_wcnt_width(TIMEOUT_CYC);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYC - 1);

   rvga_wait_state_e  state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;

   assign stall_o = req_i & ~resp_i;

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      timeout_o = 1'b0;
      case (state_q)
         WAIT_IDLE: begin
            if (stall_o) begin
               state_d = WAIT_BUSY;
               wcnt_d  = WCNT_W'(1);
            end
         end
         WAIT_BUSY: begin
            // A withdrawn request ends the wait just like a response does.
            if (resp_i || !req_i) begin
               state_d = WAIT_IDLE;
               wcnt_d  = '0;
            end else begin
               if (wcnt_q != '1) begin
                  wcnt_d = wcnt_q + WCNT_W'(1);
               end
               timeout_o = (wcnt_q == WCNT_LAST);
            end
         end
         default: begin
            state_d = WAIT_IDLE;
            wcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= WAIT_IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

endmodule

// File: rtl/rvga_hazard_ctrl.sv
// Pipeline hazard/stall controller: per-stage stall and bubble vectors from the
// memory handshakes and branch flags, plus wait timeout and stall statistics.
module rvga_hazard_ctrl
   import rvga_types::*;
#(
   parameter int NUM_STAGES  = 6,
   parameter int MEM_STAGE   = 4,
   parameter int TIMEOUT_CYC = RVGA_TIMEOUT_CYC,
   parameter int CNT_W       = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  imem_req_v_i,
   input  logic                  imem_resp_v_i,
   input  logic                  dmem_req_v_i,
   input  logic                  dmem_resp_v_i,
   input  logic [NUM_STAGES-1:0] br_v_i,
   output logic [NUM_STAGES-1:0] stall_v_o,
   output logic [NUM_STAGES-2:0] flush_v_o,
   output logic                  err_timeout_o,
   output logic [CNT_W-1:0]      imem_stall_cnt_o,
   output logic [CNT_W-1:0]      dmem_stall_cnt_o,
   output logic [CNT_W-1:0]      br_stall_cnt_o
);

   if (NUM_STAGES < 3) begin : g_bad_num_stages
      $error("rvga_hazard_ctrl: NUM_STAGES must be >= 3");
   end
   if (MEM_STAGE < 1 || MEM_STAGE > NUM_STAGES - 2) begin : g_bad_mem_stage
      $error("rvga_hazard_ctrl: MEM_STAGE must be in 1..NUM_STAGES-2");
   end
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("rvga_hazard_ctrl: TIMEOUT_CYC must be >= 2");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("rvga_hazard_ctrl: CNT_W must be >= 1");
   end

   logic imem_stall, dmem_stall, br_pend;
   logic imem_timeout, dmem_timeout;
   logic err_q, err_d;
   logic unused_br_edges;

   rvga_mem_wait_fsm #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_imem_wait (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (imem_req_v_i),
      .resp_i    (imem_resp_v_i),
      .stall_o   (imem_stall),
      .timeout_o (imem_timeout)
   );

   rvga_mem_wait_fsm #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_dmem_wait (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (dmem_req_v_i),
      .resp_i    (dmem_resp_v_i),
      .stall_o   (dmem_stall),
      .timeout_o (dmem_timeout)
   );

   // Fetch cannot hold a branch; a branch in writeback is the redirect itself.
   assign br_pend         = |br_v_i[NUM_STAGES-2:1];
   assign unused_br_edges = br_v_i[0] ^ br_v_i[NUM_STAGES-1];

   always_comb begin
      stall_v_o = '0;
      if (!rst_i) begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            if (i == 0) begin
               stall_v_o[i] = dmem_stall | imem_stall | br_pend;
            end else if (i <= MEM_STAGE) begin
               stall_v_o[i] = dmem_stall;
            end
         end
      end
   end

   // Bubble wherever a holding stage feeds a stage that keeps moving.
   always_comb begin
      flush_v_o = '1;
      if (!rst_i) begin
         for (int i = 0; i < NUM_STAGES - 1; i++) begin
            flush_v_o[i] = stall_v_o[i] & ~stall_v_o[i+1];
         end
      end
   end

   always_comb begin
      err_d = err_q | imem_timeout | dmem_timeout;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_timeout_o = err_q;

   // Index 0: imem, 1: dmem, 2: branch (only when no memory stall is active).
   logic [2:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_val [3];

   assign cnt_inc = {br_pend & ~imem_stall & ~dmem_stall, dmem_stall, imem_stall};

   for (genvar g = 0; g < 3; g++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (cnt_inc[g] && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cnt_val[g] = cnt_q;
   end

   assign imem_stall_cnt_o = cnt_val[0];
   assign dmem_stall_cnt_o = cnt_val[1];
   assign br_stall_cnt_o   = cnt_val[2];

endmodule

// File: tb/tb_rvga_hazard_ctrl.sv
// Directed bench for rvga_hazard_ctrl with hand-computed expectations
// (NUM_STAGES=6, MEM_STAGE=4, TIMEOUT_CYC=16, CNT_W=8).
module tb_rvga_hazard_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       imem_req_v_i = 1'b0;
   logic       imem_resp_v_i = 1'b0;
   logic       dmem_req_v_i = 1'b0;
   logic       dmem_resp_v_i = 1'b0;
   logic [5:0] br_v_i = '0;
   logic [5:0] stall_v_o;
   logic [4:0] flush_v_o;
   logic       err_timeout_o;
   logic [7:0] imem_stall_cnt_o;
   logic [7:0] dmem_stall_cnt_o;
   logic [7:0] br_stall_cnt_o;

   int vectors = 0;
   int miscompares = 0;

   rvga_hazard_ctrl #(
      .NUM_STAGES  (6),
      .MEM_STAGE   (4),
      .TIMEOUT_CYC (16),
      .CNT_W       (8)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .imem_req_v_i     (imem_req_v_i),
      .imem_resp_v_i    (imem_resp_v_i),
      .dmem_req_v_i     (dmem_req_v_i),
      .dmem_resp_v_i    (dmem_resp_v_i),
      .br_v_i           (br_v_i),
      .stall_v_o        (stall_v_o),
      .flush_v_o        (flush_v_o),
      .err_timeout_o    (err_timeout_o),
      .imem_stall_cnt_o (imem_stall_cnt_o),
      .dmem_stall_cnt_o (dmem_stall_cnt_o),
      .br_stall_cnt_o   (br_stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ireq, input logic iresp, input logic dreq,
                                input logic dresp, input logic [5:0] br);
      imem_req_v_i  = ireq;
      imem_resp_v_i = iresp;
      dmem_req_v_i  = dreq;
      dmem_resp_v_i = dresp;
      br_v_i        = br;
   endtask

   task automatic stepCycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkComb(input string tag, input logic [5:0] stall_exp, input logic [4:0] flush_exp);
      #2;
      checkOutput({tag, " stall"}, 32'(stall_v_o), 32'(stall_exp));
      checkOutput({tag, " flush"}, 32'(flush_v_o), 32'(flush_exp));
   endtask

   task automatic checkCounters(input string tag, input int icnt, input int dcnt, input int bcnt);
      checkOutput({tag, " imem_cnt"}, 32'(imem_stall_cnt_o), 32'(icnt));
      checkOutput({tag, " dmem_cnt"}, 32'(dmem_stall_cnt_o), 32'(dcnt));
      checkOutput({tag, " br_cnt"}, 32'(br_stall_cnt_o), 32'(bcnt));
   endtask

   initial begin
      $display("[TB] start");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b000000);
      stepCycle();
      stepCycle();
      checkComb("reset", 6'b000000, 5'b11111);
      checkOutput("reset err", 32'(err_timeout_o), 32'd0);
      checkCounters("reset", 0, 0, 0);
      rst_i = 1'b0;

      // Reset landing in the middle of a dmem wait
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6'b000000);
      checkComb("t1 wait", 6'b011111, 5'b10000);
      stepCycle();
      stepCycle();
      stepCycle();
      checkCounters("t1 pre", 0, 3, 0);
      #3;
      rst_i = 1'b1;
      #1;
      checkOutput("t1 rst stall", 32'(stall_v_o), 32'd0);
      checkOutput("t1 rst flush", 32'(flush_v_o), 32'h1F);
      checkOutput("t1 rst err", 32'(err_timeout_o), 32'd0);
      checkCounters("t1 rst", 0, 0, 0);
      stepCycle();
      rst_i = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b000000);
      checkComb("t1 idle", 6'b000000, 5'b00000);
      stepCycle();
      checkCounters("t1 post", 0, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 6'b000000);
      checkComb("t1 fast resp", 6'b000000, 5'b00000);
      stepCycle();
      checkCounters("t1 fast", 0, 0, 0);

      // dmem request held three cycles, response on the third
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6'b000000);
      checkComb("t2 c1", 6'b011111, 5'b10000);
      stepCycle();
      checkComb("t2 c2", 6'b011111, 5'b10000);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 6'b000000);
      checkComb("t2 c3", 6'b000000, 5'b00000);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b000000);
      checkCounters("t2", 0, 2, 0);

      // Branch travelling from stage 2 to writeback
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b000100);
      checkComb("t3 s2", 6'b000001, 5'b00001);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b001000);
      checkComb("t3 s3", 6'b000001, 5'b00001);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b010000);
      checkComb("t3 s4", 6'b000001, 5'b00001);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b100000);
      checkComb("t3 s5", 6'b000000, 5'b00000);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b000000);
      checkCounters("t3", 0, 2, 3);

      // Simultaneous imem and dmem stall with a branch pending
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 6'b000010);
      checkComb("t4 both", 6'b011111, 5'b10000);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b000000);
      checkCounters("t4 both", 1, 3, 3);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'b000000);
      checkComb("t4 imem", 6'b000001, 5'b00001);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b000000);
      checkCounters("t4 imem", 2, 3, 3);

      // dmem wait long enough to trip the timeout
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6'b000000);
      for (int k = 1; k <= 20; k++) begin
         stepCycle();
         checkOutput($sformatf("t5 err k=%0d", k), 32'(err_timeout_o), 32'(k >= 16));
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 6'b000000);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b000000);
      stepCycle();
      checkOutput("t5 err sticky", 32'(err_timeout_o), 32'd1);
      checkCounters("t5", 2, 23, 3);
      #3;
      rst_i = 1'b1;
      #1;
      checkOutput("t5 err cleared", 32'(err_timeout_o), 32'd0);
      stepCycle();
      rst_i = 1'b0;
      checkCounters("t5 rst", 0, 0, 0);

      // Long imem stall saturating the counter
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'b000000);
      for (int k = 1; k <= 300; k++) begin
         stepCycle();
         if (k == 10 || k == 254 || k == 255 || k == 256 || k == 300) begin
            checkOutput($sformatf("t6 imem_cnt k=%0d", k), 32'(imem_stall_cnt_o), 32'(k > 255 ? 255 : k));
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b000000);
      stepCycle();
      checkOutput("t6 imem_cnt held", 32'(imem_stall_cnt_o), 32'hFF);
      checkOutput("t6 err imem", 32'(err_timeout_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
